// File: rtl/rf_write_queue.sv
// rf_write_queue
//   Write-side front end for the 32x32 register file. Results arrive over a
//   valid/ready stream and go into an in-order FIFO. One entry per cycle
//   drains into a registered RF write port. The block also reports
//   per-register "write pending" status to the operand-read stage.
//
//   Optional feature macro: RF_WQ_FORWARD_EN
//     When defined, fwd_data_1/fwd_data_2 carry the data of the youngest
//     outstanding write to each queried register. The output register is the
//     oldest candidate, then FIFO entries from oldest to youngest.
//
// Ports
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input stream handshake (in_ready = count < DEPTH)
//   in_reg, in_data       destination register / result (in_reg==0 is dropped)
//   drain_en              RF write port granted this cycle
//   rf_we/waddr/wdata     registered RF write port
//   query_reg_1/2         operand register indices from the read stage
//   pending_1/2           outstanding write exists for the queried register
//   count, empty          FIFO occupancy
//   fwd_data_1/2          (RF_WQ_FORWARD_EN only) forwarded data

module rf_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [AW-1:0]            in_reg,
  input  logic [DW-1:0]            in_data,
  input  logic                     drain_en,
  output logic                     rf_we,
  output logic [AW-1:0]            rf_waddr,
  output logic [DW-1:0]            rf_wdata,
  input  logic [AW-1:0]            query_reg_1,
  input  logic [AW-1:0]            query_reg_2,
  output logic                     pending_1,
  output logic                     pending_2,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
`ifdef RF_WQ_FORWARD_EN
  ,
  output logic [DW-1:0]            fwd_data_1,
  output logic [DW-1:0]            fwd_data_2
`endif
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] r_mem_reg  [DEPTH];
  logic [DW-1:0] r_mem_data [DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW:0]   r_count;
  logic          r_we;
  logic [AW-1:0] r_waddr;
  logic [DW-1:0] r_wdata;

  logic          w_ready;
  logic          w_accept;
  logic          w_push;
  logic          w_pop;
  logic          w_pend1;
  logic          w_pend2;
  logic [PW-1:0] w_idx;

  // in_ready ignores a same-cycle pop, so a full queue never accepts.
  assign w_ready  = (r_count != (PW+1)'(DEPTH));
  assign w_accept = in_valid && w_ready;
  // Writes to r0 complete the handshake but are never stored.
  assign w_push   = w_accept && (in_reg != '0);
  assign w_pop    = drain_en && (r_count != '0);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr  <= r_rptr + PW'(1);
        r_we    <= 1'b1;
        r_waddr <= r_mem_reg[r_rptr];
        r_wdata <= r_mem_data[r_rptr];
      end else begin
        r_we    <= 1'b0;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; validity is defined purely by pointers/count.
  always_ff @(posedge clk) begin
    if (rst_n && w_push) begin
      r_mem_reg[r_wptr]  <= in_reg;
      r_mem_data[r_wptr] <= in_data;
    end
  end

  // Walk entries by age (k=0 oldest). Later matches overwrite earlier ones,
  // so the forwarded value ends up being the youngest matching write.
  always_comb begin
    w_pend1 = r_we && (r_waddr == query_reg_1);
    w_pend2 = r_we && (r_waddr == query_reg_2);
    w_idx   = '0;
`ifdef RF_WQ_FORWARD_EN
    fwd_data_1 = (r_we && (r_waddr == query_reg_1)) ? r_wdata : '0;
    fwd_data_2 = (r_we && (r_waddr == query_reg_2)) ? r_wdata : '0;
`endif
    for (int unsigned k = 0; k < DEPTH; k++) begin
      w_idx = r_rptr + PW'(k);
      if (k < 32'(r_count)) begin
        if (r_mem_reg[w_idx] == query_reg_1) begin
          w_pend1 = 1'b1;
`ifdef RF_WQ_FORWARD_EN
          fwd_data_1 = r_mem_data[w_idx];
`endif
        end
        if (r_mem_reg[w_idx] == query_reg_2) begin
          w_pend2 = 1'b1;
`ifdef RF_WQ_FORWARD_EN
          fwd_data_2 = r_mem_data[w_idx];
`endif
        end
      end
    end
    if (query_reg_1 == '0) begin
      w_pend1 = 1'b0;
`ifdef RF_WQ_FORWARD_EN
      fwd_data_1 = '0;
`endif
    end
    if (query_reg_2 == '0) begin
      w_pend2 = 1'b0;
`ifdef RF_WQ_FORWARD_EN
      fwd_data_2 = '0;
`endif
    end
  end

  assign in_ready  = w_ready;
  assign rf_we     = r_we;
  assign rf_waddr  = r_waddr;
  assign rf_wdata  = r_wdata;
  assign pending_1 = w_pend1;
  assign pending_2 = w_pend2;
  assign count     = r_count;
  assign empty     = (r_count == '0);

endmodule

// File: tb/tb_rf_write_queue.sv
// Testbench for rf_write_queue: directed vector table, hand-written corner
// sequences and randomized traffic, all compared against a queue-based model.
module tb_rf_write_queue;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, drain_en, rf_we, pending_1, pending_2, empty;
  logic [4:0]  in_reg, rf_waddr, query_reg_1, query_reg_2;
  logic [31:0] in_data, rf_wdata;
  logic [2:0]  count;
`ifdef RF_WQ_FORWARD_EN
  logic [31:0] fwd_data_1, fwd_data_2;
`endif

  rf_write_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_reg(in_reg), .in_data(in_data), .drain_en(drain_en),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .query_reg_1(query_reg_1), .query_reg_2(query_reg_2),
    .pending_1(pending_1), .pending_2(pending_2),
    .count(count), .empty(empty)
`ifdef RF_WQ_FORWARD_EN
    , .fwd_data_1(fwd_data_1), .fwd_data_2(fwd_data_2)
`endif
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [4:0] r; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  logic        m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  function automatic logic m_pend(input logic [4:0] q);
    if (q == 0) return 1'b0;
    if (m_we && m_wa == q) return 1'b1;
    foreach (mq[i]) if (mq[i].r == q) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_fwd(input logic [4:0] q);
    if (q == 0) return 32'h0;
    for (int i = mq.size() - 1; i >= 0; i--) if (mq[i].r == q) return mq[i].d;
    if (m_we && m_wa == q) return m_wd;
    return 32'h0;
  endfunction

  task automatic model_edge();
    ent_t e;
    bit   rdy;
    if (!rst_n) begin
      mq.delete(); m_we = 1'b0; m_wa = '0; m_wd = '0;
    end else begin
      rdy = (mq.size() < DEPTH);
      if (drain_en && mq.size() > 0) begin
        e = mq.pop_front(); m_we = 1'b1; m_wa = e.r; m_wd = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (in_valid && rdy && in_reg != 0) begin
        e.r = in_reg; e.d = in_data; mq.push_back(e);
      end
    end
  endtask

  // Apply inputs (at negedge) and compare every output against the model.
  task automatic drive(input logic rs, input logic v, input logic [4:0] rg,
                       input logic [31:0] dt, input logic dr,
                       input logic [4:0] q1, input logic [4:0] q2);
    rst_n = rs; in_valid = v; in_reg = rg; in_data = dt; drain_en = dr;
    query_reg_1 = q1; query_reg_2 = q2;
    #1;
    chk("in_ready",  in_ready,  mq.size() < DEPTH);
    chk("count",     count,     mq.size());
    chk("empty",     empty,     mq.size() == 0);
    chk("rf_we",     rf_we,     m_we);
    chk("rf_waddr",  rf_waddr,  m_wa);
    chk("rf_wdata",  rf_wdata,  m_wd);
    chk("pending_1", pending_1, m_pend(q1));
    chk("pending_2", pending_2, m_pend(q2));
`ifdef RF_WQ_FORWARD_EN
    chk("fwd_data_1", fwd_data_1, m_fwd(q1));
    chk("fwd_data_2", fwd_data_2, m_fwd(q2));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic rs; logic v; logic [4:0] rg; logic [31:0] dt; logic dr;
    logic [4:0] q1; logic [4:0] q2;
    logic [2:0] e_cnt; logic e_rdy; logic e_we; logic [4:0] e_wa;
    logic [31:0] e_wd; logic e_p1; logic e_p2;
  } vec_t;

  function automatic vec_t mk(logic rs, logic v, logic [4:0] rg, logic [31:0] dt,
                              logic dr, logic [4:0] q1, logic [4:0] q2,
                              logic [2:0] c, logic rdy, logic we, logic [4:0] wa,
                              logic [31:0] wd, logic p1, logic p2);
    vec_t t;
    t.rs = rs; t.v = v; t.rg = rg; t.dt = dt; t.dr = dr; t.q1 = q1; t.q2 = q2;
    t.e_cnt = c; t.e_rdy = rdy; t.e_we = we; t.e_wa = wa; t.e_wd = wd;
    t.e_p1 = p1; t.e_p2 = p2;
    return t;
  endfunction

  vec_t tbl[$];

  initial begin
    // single push/drain latency
    tbl.push_back(mk(1,1,5,32'hDEADBEEF,1,5,0, 0,1,0,0,32'h0,       0,0));
    tbl.push_back(mk(1,0,0,32'h0,       1,5,0, 1,1,0,0,32'h0,       1,0));
    tbl.push_back(mk(1,0,0,32'h0,       1,5,0, 0,1,1,5,32'hDEADBEEF,1,0));
    tbl.push_back(mk(1,0,0,32'h0,       1,5,0, 0,1,0,5,32'hDEADBEEF,0,0));
    // fill with drain stalled, refuse a fifth push, then drain in order
    tbl.push_back(mk(1,1,1,32'h101,0,1,4, 0,1,0,5,32'hDEADBEEF,0,0));
    tbl.push_back(mk(1,1,2,32'h102,0,1,4, 1,1,0,5,32'hDEADBEEF,1,0));
    tbl.push_back(mk(1,1,3,32'h103,0,1,4, 2,1,0,5,32'hDEADBEEF,1,0));
    tbl.push_back(mk(1,1,4,32'h104,0,1,4, 3,1,0,5,32'hDEADBEEF,1,0));
    tbl.push_back(mk(1,1,6,32'h106,0,6,4, 4,0,0,5,32'hDEADBEEF,0,1));
    tbl.push_back(mk(1,0,0,32'h0,  1,6,1, 4,0,0,5,32'hDEADBEEF,0,1));
    tbl.push_back(mk(1,0,0,32'h0,  1,6,1, 3,1,1,1,32'h101,0,1));
    tbl.push_back(mk(1,0,0,32'h0,  1,6,1, 2,1,1,2,32'h102,0,0));
    tbl.push_back(mk(1,0,0,32'h0,  1,6,1, 1,1,1,3,32'h103,0,0));
    tbl.push_back(mk(1,0,0,32'h0,  1,6,1, 0,1,1,4,32'h104,0,0));
    tbl.push_back(mk(1,0,0,32'h0,  0,6,1, 0,1,0,4,32'h104,0,0));
    // write to r0 is swallowed
    tbl.push_back(mk(1,1,0,32'h1234,1,0,0, 0,1,0,4,32'h104,0,0));
    tbl.push_back(mk(1,0,0,32'h0,   1,0,0, 0,1,0,4,32'h104,0,0));

    // reset
    rst_n = 1'b0; in_valid = 1'b0; in_reg = '0; in_data = '0; drain_en = 1'b0;
    query_reg_1 = '0; query_reg_2 = '0;
    @(negedge clk);
    tick(); tick();

    foreach (tbl[i]) begin
      drive(tbl[i].rs, tbl[i].v, tbl[i].rg, tbl[i].dt, tbl[i].dr, tbl[i].q1, tbl[i].q2);
      chk("tbl_count",   count,     tbl[i].e_cnt);
      chk("tbl_ready",   in_ready,  tbl[i].e_rdy);
      chk("tbl_we",      rf_we,     tbl[i].e_we);
      chk("tbl_waddr",   rf_waddr,  tbl[i].e_wa);
      chk("tbl_wdata",   rf_wdata,  tbl[i].e_wd);
      chk("tbl_pend1",   pending_1, tbl[i].e_p1);
      chk("tbl_pend2",   pending_2, tbl[i].e_p2);
      tick();
    end

    // full queue with drain and push together, then 3 wrap-arounds
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 5'(8 + i), 32'h800 + 32'(i), 0, 8, 0);
      tick();
    end
    drive(1, 1, 12, 32'hC00, 1, 12, 8);
    chk("full_ready", in_ready, 1'b0);
    tick();
    drive(1, 1, 13, 32'hD00, 1, 12, 8);
    chk("after_pop_ready", in_ready, 1'b1);
    tick();
    for (int i = 0; i < 12; i++) begin
      drive(1, 1, 5'(1 + (i % 30)), 32'hA000 + 32'(i), 1, 5'(1 + (i % 30)), 13);
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      drive(1, 0, 0, 0, 1, 3, 12);
      tick();
    end

    // two writes to the same register
    drive(1, 1, 7, 32'hA, 0, 7, 0); tick();
    drive(1, 1, 7, 32'hB, 0, 7, 0); tick();
    drive(1, 0, 0, 0, 0, 7, 0);
    chk("same_reg_pend", pending_1, 1'b1);
`ifdef RF_WQ_FORWARD_EN
    chk("same_reg_fwd", fwd_data_1, 32'hB);
`endif
    tick();
    drive(1, 0, 0, 0, 1, 7, 0); tick();
    drive(1, 0, 0, 0, 0, 7, 0);
    chk("same_reg_pend_mid", pending_1, 1'b1);
    chk("same_reg_first", rf_wdata, 32'hA);
`ifdef RF_WQ_FORWARD_EN
    chk("same_reg_fwd_mid", fwd_data_1, 32'hB);
`endif
    tick();
    drive(1, 0, 0, 0, 1, 7, 0); tick();
    drive(1, 0, 0, 0, 0, 7, 0);
    chk("same_reg_second", rf_wdata, 32'hB);
    tick();

    // reset while holding 3 entries and mid-drain
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, 5'(9 + i), 32'h900 + 32'(i), 0, 10, 11);
      tick();
    end
    drive(1, 0, 0, 0, 1, 10, 9); tick();
    drive(0, 0, 0, 0, 1, 10, 9);
    chk("pre_rst_count", count, 3'd3);
    chk("pre_rst_we", rf_we, 1'b1);
    tick();
    drive(1, 0, 0, 0, 1, 10, 9);
    chk("post_rst_count", count, 3'd0);
    chk("post_rst_we", rf_we, 1'b0);
    chk("post_rst_pend", pending_1, 1'b0);
    chk("post_rst_ready", in_ready, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(1, 0, 0, 0, 1, 10, 9);
      chk("post_rst_no_write", rf_we, 1'b0);
      tick();
    end

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      drive(($urandom_range(0, 59) != 0), $urandom_range(0, 1),
            5'($urandom_range(0, 7)), $urandom, ($urandom_range(0, 2) != 0),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
